sram_resp_soc: RTL and testbench
================================

// Module: sram_resp_soc
// PURPOSE
// - Responder side of the core's inst_sram/data_sram interfaces: backing word RAM
//   shared by both ports, plus a small MMIO register page (LED, switch, scratch, timer).
// - Sits beside mycpu_core in the SoC top. Fixed 1-cycle read latency, no stall/handshake back to core.
// PARAMETERS
// - ADDR_W     14           word-address bits of RAM (2^ADDR_W x 32b; default 64 KiB)
// - MMIO_PAGE  16'h1FAF     phys addr[31:16] selecting the MMIO page
// - INIT_FILE  ""           $readmemh image for RAM; empty = RAM contents undefined
// PORTS
// - clk              in   1   clock, all logic on posedge
// - rst              in   1   synchronous reset, active-low
// - inst_sram_en     in   1   instruction access request
// - inst_sram_wen    in   4   byte write enables (ignored; inst port read-only)
// - inst_sram_addr   in   32  byte address (virtual)
// - inst_sram_wdata  in   32  ignored
// - inst_sram_rdata  out  32  read data, valid cycle after request
// - data_sram_en     in   1   data access request
// - data_sram_wen    in   4   byte write enables; 0 = read
// - data_sram_addr   in   32  byte address (virtual)
// - data_sram_wdata  in   32  write data, lane i = bits [8i+7:8i]
// - data_sram_rdata  out  32  read data, valid cycle after request
// - led              out  16  LED register
// - switch_in        in   8   asynchronous switch inputs
// BEHAVIOUR
// - Reset (rst==0 at posedge): inst_sram_rdata=0, data_sram_rdata=0, led=16'h0000, scratch=0,
//   timer=0, switch sync flops=0. RAM contents not reset. Reset mid-access: pending rdata discarded (0).
// - Phys addr = addr & 32'h1FFF_FFFF. MMIO if phys[31:16]==MMIO_PAGE, else RAM.
//   RAM word index = phys[ADDR_W+1:2]; higher bits ignored (aliasing); addr[1:0] ignored.
// - Read: en=1 at edge N -> rdata valid after edge N+1... precisely: rdata register loads at edge N,
//   visible during cycle N+1. en=0 -> rdata holds previous value.
// - Data write: en=1, wen!=0: lanes with wen[i]=1 updated at edge; others unchanged.
//   Write cycle also loads data_sram_rdata with OLD word (read-first).
// - Inst port: never writes. Same-word data write + inst read same cycle -> inst gets OLD word.
//   Inst access to MMIO page -> inst_sram_rdata=0.
// - MMIO map (phys[15:0]); byte enables apply per lane; unmapped read 0, write ignored:
//   16'hF000 LED     RW  bits[15:0]; upper bits read 0
//   16'hF004 SWITCH  RO  {24'b0, sw_sync}; sw_sync = 2-flop sync of switch_in
//   16'hF008 SCRATCH RW  32 bits
//   16'hE000 TIMER   RW  see CONFIGURATION
// - MMIO reads also read-first: write+read same register same cycle returns old value.
// CONFIGURATION
// - Macro SRAM_RESP_TIMER_EN.
// - Defined: TIMER is 32b free-running, +1 every cycle out of reset, wraps FFFF_FFFF->0.
//   Write at edge N: masked lanes take wdata, unmasked lanes take timer+1 at edge N; increment resumes
//   from that value at N+1. Read returns value before edge N.
// - Not defined: no timer flops; 16'hE000 reads 0, writes ignored.
// TESTING
// - Reset 3 cycles, read 0x1FAF_F000 -> rdata 0 next cycle; led==0; rdata regs 0 during reset.
// - Write 0x8000_0010 wdata 0xA1B2_C3D4 wen 4'b0101, word was 0 -> read 0xA000_0010 gives 0x00B2_00D4.
// - Same cycle: data write 0xDEAD_BEEF to 0x0000_0020, inst read 0xBFC0_0020 (same word, old 0x1234)
//   -> inst_sram_rdata 0x1234; next inst read -> 0xDEAD_BEEF.
// - Write LED 0x0000_5A5A at 0xBFAF_F000 -> led=16'h5A5A next cycle; switch_in=8'h3C -> SWITCH reads 0x3C
//   within 3 cycles; read 0xBFAF_F0FC -> 0.
// - TIMER_EN: write 0xFFFF_FFFE wen 4'hF, read 2 cycles later -> 0xFFFF_FFFF then 0x0000_0000 (wrap).
//   Without macro: same write then read -> 0.

Source files
------------

// File: rtl/sram_resp_soc.sv
// sram_resp_soc: responder for the core's inst_sram / data_sram ports.
// One word RAM shared by both ports (inst port read-only) plus an MMIO page
// holding LED, SWITCH, SCRATCH and (optionally) TIMER registers.
// Both ports have a fixed 1-cycle read latency and are read-first.
// Optional feature macro: SRAM_RESP_TIMER_EN (free-running 32-bit timer at 16'hE000).
module sram_resp_soc #(
   parameter int          ADDR_W    = 14,
   parameter logic [15:0] MMIO_PAGE = 16'h1FAF,
   parameter              INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_sram_en,
   input  logic [3:0]  inst_sram_wen,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   input  logic [7:0]  switch_in
);

   localparam logic [15:0] OFF_LED     = 16'hF000;
   localparam logic [15:0] OFF_SWITCH  = 16'hF004;
   localparam logic [15:0] OFF_SCRATCH = 16'hF008;
   localparam logic [15:0] OFF_TIMER   = 16'hE000;

   // Byte-lane merge: lanes with be[i]=1 take new_v, others keep old_v.
   function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   // Address decode: strip the segment bits, then page-compare for MMIO.
   logic [31:0]       inst_phys, data_phys;
   logic              inst_is_mmio, data_is_mmio;
   logic [ADDR_W-1:0] inst_idx, data_idx;
   logic [15:0]       data_off;
   logic              data_wr;

   assign inst_phys    = inst_sram_addr & 32'h1FFF_FFFF;
   assign data_phys    = data_sram_addr & 32'h1FFF_FFFF;
   assign inst_is_mmio = (inst_phys[31:16] == MMIO_PAGE);
   assign data_is_mmio = (data_phys[31:16] == MMIO_PAGE);
   assign inst_idx     = inst_phys[ADDR_W+1:2];
   assign data_idx     = data_phys[ADDR_W+1:2];
   assign data_off     = data_phys[15:0];
   assign data_wr      = data_sram_en && (data_sram_wen != 4'b0000);

   // Inst-port write strobes/data and the masked address bits are intentionally dropped.
   logic unused_bits;
   assign unused_bits = ^{inst_sram_wen, inst_sram_wdata, inst_phys, data_phys};

   logic [15:0] led_reg;
   logic [31:0] scratch_reg;
   logic [7:0]  sw_meta_reg, sw_sync_reg;
   logic [31:0] led_next, scratch_next;
   logic        led_wr, scratch_wr, timer_wr;
   logic [31:0] timer_rd;

   assign led_wr     = data_wr && data_is_mmio && (data_off == OFF_LED);
   assign scratch_wr = data_wr && data_is_mmio && (data_off == OFF_SCRATCH);
   assign timer_wr   = data_wr && data_is_mmio && (data_off == OFF_TIMER);
   assign led_next     = lane_merge({16'h0000, led_reg}, data_sram_wdata, data_sram_wen);
   assign scratch_next = lane_merge(scratch_reg, data_sram_wdata, data_sram_wen);
   assign led = led_reg;

`ifdef SRAM_RESP_TIMER_EN
   logic [31:0] timer_reg;
   logic [31:0] timer_inc;
   assign timer_inc = timer_reg + 32'd1;
   assign timer_rd  = timer_reg;

   // Free-running timer; a write overrides only the enabled lanes of this cycle's increment.
   always_ff @(posedge clk) begin
      if (!rst)          timer_reg <= 32'h0;
      else if (timer_wr) timer_reg <= lane_merge(timer_inc, data_sram_wdata, data_sram_wen);
      else               timer_reg <= timer_inc;
   end
`else
   logic unused_timer;
   assign timer_rd     = 32'h0;
   assign unused_timer = timer_wr;
`endif

   // MMIO read mux (old register values, giving read-first behaviour).
   logic [31:0] mmio_rdata;
   always_comb begin
      mmio_rdata = 32'h0;
      case (data_off)
         OFF_LED:     mmio_rdata = {16'h0000, led_reg};
         OFF_SWITCH:  mmio_rdata = {24'h0, sw_sync_reg};
         OFF_SCRATCH: mmio_rdata = scratch_reg;
         OFF_TIMER:   mmio_rdata = timer_rd;
         default:     mmio_rdata = 32'h0;
      endcase
   end

   // MMIO registers and the two-flop switch synchroniser.
   always_ff @(posedge clk) begin
      if (!rst) begin
         led_reg     <= 16'h0000;
         scratch_reg <= 32'h0;
         sw_meta_reg <= 8'h00;
         sw_sync_reg <= 8'h00;
      end else begin
         sw_meta_reg <= switch_in;
         sw_sync_reg <= sw_meta_reg;
         if (led_wr)     led_reg     <= led_next[15:0];
         if (scratch_wr) scratch_reg <= scratch_next;
      end
   end

   // RAM byte-lane writes from the data port; contents are never reset.
   always_ff @(posedge clk) begin
      if (rst && data_wr && !data_is_mmio) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) mem[data_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
         end
      end
   end

   // Registered read data for both ports; holds when the port is idle.
   logic [31:0] inst_rdata_reg, data_rdata_reg;
   always_ff @(posedge clk) begin
      if (!rst) begin
         inst_rdata_reg <= 32'h0;
         data_rdata_reg <= 32'h0;
      end else begin
         if (inst_sram_en) inst_rdata_reg <= inst_is_mmio ? 32'h0 : mem[inst_idx];
         if (data_sram_en) data_rdata_reg <= data_is_mmio ? mmio_rdata : mem[data_idx];
      end
   end

   assign inst_sram_rdata = inst_rdata_reg;
   assign data_sram_rdata = data_rdata_reg;

endmodule

// File: tb/tb_sram_resp_soc.sv
// Directed bench for sram_resp_soc: expected read data is queued when a request
// is driven and compared once the following clock edge has loaded rdata.
module tb_sram_resp_soc;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_sram_en = 1'b0;
   logic [3:0]  inst_sram_wen = 4'h0;
   logic [31:0] inst_sram_addr = 32'h0;
   logic [31:0] inst_sram_wdata = 32'h0;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_en = 1'b0;
   logic [3:0]  data_sram_wen = 4'h0;
   logic [31:0] data_sram_addr = 32'h0;
   logic [31:0] data_sram_wdata = 32'h0;
   logic [31:0] data_sram_rdata;
   logic [15:0] led;
   logic [7:0]  switch_in = 8'h00;

   sram_resp_soc dut (
      .clk(clk), .rst(rst),
      .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_rdata(inst_sram_rdata),
      .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_rdata(data_sram_rdata),
      .led(led), .switch_in(switch_in)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      bit          is_inst;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

`ifdef SRAM_RESP_TIMER_EN
   localparam logic [31:0] TIMER_EXP0 = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] TIMER_EXP0 = 32'h0000_0000;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      $display("[TB] %-10s obs=%h exp=%h", tag, obs, expv);
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic dreq(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata,
                       input bit check, input string tag, input logic [31:0] expv);
      exp_t e;
      data_sram_en    = 1'b1;
      data_sram_addr  = addr;
      data_sram_wen   = wen;
      data_sram_wdata = wdata;
      if (check) begin
         e.tag = tag; e.is_inst = 1'b0; e.val = expv;
         exp_q.push_back(e);
      end
   endtask

   task automatic ireq(input logic [31:0] addr, input string tag, input logic [31:0] expv);
      exp_t e;
      inst_sram_en   = 1'b1;
      inst_sram_addr = addr;
      e.tag = tag; e.is_inst = 1'b1; e.val = expv;
      exp_q.push_back(e);
   endtask

   // Advance one edge, release requests, then retire everything queued for this edge.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      data_sram_en  = 1'b0;
      data_sram_wen = 4'h0;
      inst_sram_en  = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk(e.tag, e.is_inst ? inst_sram_rdata : data_sram_rdata, e.val);
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held 3 cycles with live requests: rdata must stay 0.
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         dreq(32'h1FAF_F000, 4'h0, 32'h0, 1'b1, "rst_data", 32'h0);
         ireq(32'h0000_0000, "rst_inst", 32'h0);
         step();
      end
      chk("rst_led", {16'h0, led}, 32'h0);
      rst = 1'b1;

      dreq(32'h1FAF_F000, 4'h0, 32'h0, 1'b1, "led_rd0", 32'h0);
      step();

      // Partial-lane write into a zeroed word, read back through an alias.
      dreq(32'h0000_0010, 4'hF, 32'h0, 1'b0, "", 32'h0);                    step();
      dreq(32'h8000_0010, 4'b0101, 32'hA1B2_C3D4, 1'b0, "", 32'h0);         step();
      dreq(32'hA000_0010, 4'h0, 32'h0, 1'b1, "byte_lane", 32'h00B2_00D4);   step();

      // Same-word data write + inst read: both see the old word.
      dreq(32'h0000_0020, 4'hF, 32'h0000_1234, 1'b0, "", 32'h0);            step();
      dreq(32'h0000_0020, 4'hF, 32'hDEAD_BEEF, 1'b1, "wr_old", 32'h0000_1234);
      ireq(32'hBFC0_0020, "inst_old", 32'h0000_1234);                        step();
      ireq(32'hBFC0_0020, "inst_new", 32'hDEAD_BEEF);                        step();

      // LED register: only low 16 bits stored, upper bits read 0.
      dreq(32'hBFAF_F000, 4'hF, 32'hFFFF_5A5A, 1'b0, "", 32'h0);            step();
      chk("led_out", {16'h0, led}, 32'h0000_5A5A);
      dreq(32'hBFAF_F000, 4'h0, 32'h0, 1'b1, "led_rd", 32'h0000_5A5A);      step();

      // Switch through the two-flop synchroniser.
      switch_in = 8'h3C;
      step();
      step();
      dreq(32'hBFAF_F004, 4'h0, 32'h0, 1'b1, "switch", 32'h0000_003C);      step();

      dreq(32'hBFAF_F0FC, 4'h0, 32'h0, 1'b1, "unmapped", 32'h0);            step();

      // Scratch: read-first on write, then per-lane merge.
      dreq(32'hBFAF_F008, 4'hF, 32'h1111_2222, 1'b0, "", 32'h0);            step();
      dreq(32'hBFAF_F008, 4'b1100, 32'h3333_4444, 1'b1, "scr_rdfst", 32'h1111_2222); step();
      dreq(32'hBFAF_F008, 4'h0, 32'h0, 1'b1, "scratch", 32'h3333_2222);     step();

      ireq(32'hBFAF_F008, "inst_mmio", 32'h0);                               step();

      // Idle data port holds its last read value.
      step();
      chk("hold", data_sram_rdata, 32'h3333_2222);

      // Timer: write, skip one edge, then two reads (wrap when enabled).
      dreq(32'hBFAF_E000, 4'hF, 32'hFFFF_FFFE, 1'b0, "", 32'h0);            step();
      step();
      dreq(32'hBFAF_E000, 4'h0, 32'h0, 1'b1, "timer0", TIMER_EXP0);         step();
      dreq(32'hBFAF_E000, 4'h0, 32'h0, 1'b1, "timer1", 32'h0000_0000);      step();

      // Reset arriving with a request in flight discards it.
      rst = 1'b0;
      dreq(32'h0000_0020, 4'h0, 32'h0, 1'b1, "rst_mid", 32'h0);
      ireq(32'h0000_0020, "rst_mid_i", 32'h0);
      step();
      chk("rst_led2", {16'h0, led}, 32'h0);
      rst = 1'b1;

      // RAM survives reset.
      dreq(32'h0000_0020, 4'h0, 32'h0, 1'b1, "ram_keep", 32'hDEAD_BEEF);    step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
